wb_regfile_scoreboard: RTL and testbench
========================================

// Module: wb_regfile_scoreboard
// PURPOSE
//   Receiving end of the writeback path. Takes the selected writeback value
//   (ALU result or load data) and commits it into the 32-entry integer
//   register file. Serves the two decode-stage read ports, with same-cycle
//   write-to-read bypass. Keeps a load scoreboard so decode can stall on
//   registers whose load result has not yet been written back.
// PARAMETERS
//   XLEN   64   register / data width
//   NREG   32   number of architectural registers (x0 hardwired to zero)
//   AW     5    register address width, $clog2(NREG)
//   CNTW   32   width of the writeback commit counter
// PORTS
//   clk            in   1     single clock, all state updates on posedge
//   rst_n          in   1     reset, asynchronous, active-low
//   wb_en          in   1     writeback valid (RegWrite from WB stage)
//   wb_rd          in   AW    writeback destination register
//   wb_data        in   XLEN  writeback value from the writeback mux
//   rs1_addr       in   AW    decode read port 1 address
//   rs2_addr       in   AW    decode read port 2 address
//   rs1_data       out  XLEN  read port 1 data (combinational)
//   rs2_data       out  XLEN  read port 2 data (combinational)
//   issue_en       in   1     instruction leaving decode this cycle
//   issue_is_load  in   1     issuing instruction is a load
//   issue_rd       in   AW    destination of the issuing instruction
//   flush          in   1     pipeline flush: drop all pending loads
//   rs1_busy       out  1     rs1 awaits an outstanding load
//   rs2_busy       out  1     rs2 awaits an outstanding load
//   stall          out  1     rs1_busy | rs2_busy
//   wb_count       out  CNTW  number of committed register writes
// BEHAVIOUR
//   Reset (rst_n low, takes effect immediately, independent of clk):
//   - all registers -> 0, pending[] -> 0, wb_count -> 0
//   - hence rs*_data = 0, rs*_busy = 0, stall = 0 while in reset
//   - reset asserted mid-operation discards any in-flight write, set or clear
//   Write:
//   - on posedge, if wb_en && wb_rd != 0: reg[wb_rd] <= wb_data
//   - writes to x0 are discarded
//   - a write to x0 does not count
//   - wb_count increments by 1 per committed write
//   - wb_count wraps 2^CNTW-1 -> 0
//   Read (combinational, zero latency):
//   - addr == 0 -> 0
//   - else if wb_en && wb_rd == addr -> wb_data (bypass)
//   - else reg[addr]
//   Scoreboard (pending[NREG], bit 0 always 0), evaluated per posedge:
//   - flush = 1 -> all pending cleared; issue set ignored that cycle
//   - set: issue_en && issue_is_load && issue_rd != 0 -> pending[issue_rd] = 1
//   - clear: wb_en && wb_rd != 0 -> pending[wb_rd] = 0
//   - set and clear on the same register in the same cycle: set wins
//     (the younger load owns the register)
//   - clear on a register that is not pending: no effect
//   - rsN_busy = (rsN_addr != 0) && pending[rsN_addr]
//       && !(wb_en && wb_rd == rsN_addr), i.e. the bypass resolves the hazard
//   - stall is purely combinational, with no registered delay
// TESTING
//   1. Reset; read x0..x31 -> all 0; stall = 0; wb_count = 0.
//   2. wb_en=1, wb_rd=5, wb_data=0xDEAD_BEEF with rs1_addr=5 in the same cycle
//      -> rs1_data = 0xDEAD_BEEF (bypass); next cycle it reads from storage;
//      wb_count = 1.
//   3. wb_en=1, wb_rd=0, wb_data=0x1234 -> rs1_addr=0 reads 0; wb_count unchanged.
//   4. Issue load to x7; next cycle rs2_addr=7 -> rs2_busy=1, stall=1;
//      writeback x7=0x55 -> same cycle busy=0, rs2_data=0x55; pending[7]=0 after.
//   5. Pending x9 plus a new load issue to x9 in the same cycle as x9's
//      writeback -> pending[9] remains 1.
//      flush with an issue to x3 -> no bits pending.
//   6. Preload wb_count = 2^32-1 via writes (or force) -> one more write
//      gives 0.
//      rst_n low mid-cycle -> outputs clear without a clk edge.

Source files
------------

// File: rtl/wb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_scoreboard
// Description : Writeback-side integer register file with two combinational
//               decode read ports, same-cycle write-to-read bypass, a load
//               scoreboard producing decode stall, and a commit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_scoreboard #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            issue_en_i,
    input  logic            issue_is_load_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic            flush_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic            stall_o,
    output logic [CNTW-1:0] wb_count_o
);

    // Architectural state; entry 0 is held at zero and never written.
    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [CNTW-1:0] wb_count_q;
    logic [CNTW-1:0] wb_count_d;

    // A write is architecturally visible only when it targets x1..x31.
    logic w_wb_commit;
    logic w_issue_set;

    assign w_wb_commit = wb_en_i && (wb_rd_i != '0);
    assign w_issue_set = issue_en_i && issue_is_load_i && (issue_rd_i != '0);

    // Register file storage: commit the writeback value on each valid write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wb_commit) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // Scoreboard next state: flush dominates; a new load issue to the same
    // register as a writeback wins, since the younger load owns the register.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (w_wb_commit) begin
                pending_d[wb_rd_i] = 1'b0;
            end
            if (w_issue_set) begin
                pending_d[issue_rd_i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    // Commit counter next state; wraps naturally at 2^CNTW.
    always_comb begin
        wb_count_d = wb_count_q;
        if (w_wb_commit) begin
            wb_count_d = wb_count_q + 1'b1;
        end
    end

    // Scoreboard and counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            wb_count_q <= '0;
        end else begin
            pending_q  <= pending_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Read port 1: x0 reads zero, an in-flight writeback is forwarded.
    always_comb begin
        rs1_data_o = regs_q[rs1_addr_i];
        if (rs1_addr_i == '0) begin
            rs1_data_o = '0;
        end else if (wb_en_i && (wb_rd_i == rs1_addr_i)) begin
            rs1_data_o = wb_data_i;
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rs2_data_o = regs_q[rs2_addr_i];
        if (rs2_addr_i == '0) begin
            rs2_data_o = '0;
        end else if (wb_en_i && (wb_rd_i == rs2_addr_i)) begin
            rs2_data_o = wb_data_i;
        end
    end

    // Hazard detect: a pending source is not busy when its load result is
    // being written back this very cycle, because the bypass supplies it.
    always_comb begin
        rs1_busy_o = (rs1_addr_i != '0) && pending_q[rs1_addr_i]
                     && !(wb_en_i && (wb_rd_i == rs1_addr_i));
        rs2_busy_o = (rs2_addr_i != '0) && pending_q[rs2_addr_i]
                     && !(wb_en_i && (wb_rd_i == rs2_addr_i));
        stall_o    = rs1_busy_o || rs2_busy_o;
    end

    assign wb_count_o = wb_count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_scoreboard
// Description : Directed self-checking bench for wb_regfile_scoreboard.
//               A second instance with a 4-bit counter exercises wraparound.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_scoreboard;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            issue_en;
    logic            issue_is_load;
    logic [AW-1:0]   issue_rd;
    logic            flush;

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            stall;
    logic [31:0]     wb_count;

    logic [XLEN-1:0] s_rs1_data;
    logic [XLEN-1:0] s_rs2_data;
    logic            s_rs1_busy;
    logic            s_rs2_busy;
    logic            s_stall;
    logic [3:0]      s_wb_count;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_cnt;

    wb_regfile_scoreboard #(.XLEN(XLEN), .NREG(32), .AW(AW), .CNTW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .issue_en_i(issue_en), .issue_is_load_i(issue_is_load),
        .issue_rd_i(issue_rd), .flush_i(flush),
        .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
        .stall_o(stall), .wb_count_o(wb_count)
    );

    wb_regfile_scoreboard #(.XLEN(XLEN), .NREG(32), .AW(AW), .CNTW(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(s_rs1_data), .rs2_data_o(s_rs2_data),
        .issue_en_i(issue_en), .issue_is_load_i(issue_is_load),
        .issue_rd_i(issue_rd), .flush_i(flush),
        .rs1_busy_o(s_rs1_busy), .rs2_busy_o(s_rs2_busy),
        .stall_o(s_stall), .wb_count_o(s_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so they are stable around posedge.
    task automatic idle_inputs();
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        issue_en = 1'b0; issue_is_load = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        @(negedge clk);
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
        @(negedge clk);
        idle_inputs();
        if (rd != '0) exp_cnt = exp_cnt + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        rs1_addr = '0; rs2_addr = '0;
        #2;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(31 - i);
            #1;
            n_cmp++;
            if (rs1_data !== '0 || rs2_data !== '0) begin
                n_fail++;
                $display("FAIL reset_read x%0d: rs1=%h rs2=%h expected 0", i, rs1_data, rs2_data);
            end
        end
        n_cmp++;
        if (stall !== 1'b0 || wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b count=%0d expected 0/0", stall, wb_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        n_cmp++;
        if (wb_count !== 32'd0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: count=%0d stall=%b expected 0/0", wb_count, stall);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        #1;
        n_cmp++;
        if (rs1_data !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_rs1: got %h expected %h", rs1_data, 64'hDEAD_BEEF);
        end
        n_cmp++;
        if (rs2_data !== 64'h0) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h expected 0", rs2_data);
        end
        @(negedge clk);
        idle_inputs();
        exp_cnt = exp_cnt + 1;
        rs2_addr = 5'd5;
        #1;
        n_cmp++;
        if (rs1_data !== 64'hDEAD_BEEF || rs2_data !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL stored_x5: rs1=%h rs2=%h expected %h", rs1_data, rs2_data, 64'hDEAD_BEEF);
        end
        n_cmp++;
        if (wb_count !== 32'd1) begin
            n_fail++;
            $display("FAIL count_after_first: got %0d expected 1", wb_count);
        end
        do_write(5'd31, 64'hA5A5_0000_FFFF_1234);
        do_write(5'd1,  64'h0123_4567_89AB_CDEF);
        rs1_addr = 5'd31; rs2_addr = 5'd1;
        #1;
        n_cmp++;
        if (rs1_data !== 64'hA5A5_0000_FFFF_1234 || rs2_data !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL read_x31_x1: rs1=%h rs2=%h expected a5a50000ffff1234/0123456789abcdef",
                     rs1_data, rs2_data);
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        n_cmp++;
        if (rs1_data !== 64'h0) begin
            n_fail++;
            $display("FAIL x0_bypass: got %h expected 0", rs1_data);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (rs1_data !== 64'h0 || wb_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL x0_write: data=%h count=%0d expected 0/%0d", rs1_data, wb_count, exp_cnt);
        end
    endtask

    task automatic test_load_hazard();
        @(negedge clk);
        issue_en = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
        rs1_addr = 5'd0; rs2_addr = 5'd7;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_before_edge: got %b expected 0", rs2_busy);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b1 || stall !== 1'b1 || rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_pending: rs1_busy=%b rs2_busy=%b stall=%b expected 0/1/1",
                     rs1_busy, rs2_busy, stall);
        end
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h55;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b0 || stall !== 1'b0 || rs2_data !== 64'h55) begin
            n_fail++;
            $display("FAIL wb_resolves: busy=%b stall=%b data=%h expected 0/0/55",
                     rs2_busy, stall, rs2_data);
        end
        @(negedge clk);
        idle_inputs();
        exp_cnt = exp_cnt + 1;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b0 || rs2_data !== 64'h55) begin
            n_fail++;
            $display("FAIL pending_cleared: busy=%b data=%h expected 0/55", rs2_busy, rs2_data);
        end
        // Non-load issue and load to x0 must not mark anything pending.
        issue_en = 1'b1; issue_is_load = 1'b0; issue_rd = 5'd8;
        @(negedge clk);
        issue_is_load = 1'b1; issue_rd = 5'd0;
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd8; rs2_addr = 5'd0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL non_load_issue: rs1_busy=%b rs2_busy=%b stall=%b expected 0/0/0",
                     rs1_busy, rs2_busy, stall);
        end
    endtask

    task automatic test_set_wins_and_flush();
        @(negedge clk);
        issue_en = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        idle_inputs();
        // Older load to x9 returns while a younger load to x9 issues.
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
        issue_en = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd9;
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs1_data !== 64'h99) begin
            n_fail++;
            $display("FAIL same_cycle_bypass: busy=%b data=%h expected 0/99", rs1_busy, rs1_data);
        end
        @(negedge clk);
        idle_inputs();
        exp_cnt = exp_cnt + 1;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins: busy=%b stall=%b expected 1/1", rs1_busy, stall);
        end
        flush = 1'b1;
        issue_en = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: rs1_busy=%b rs2_busy=%b stall=%b expected 0/0/0",
                     rs1_busy, rs2_busy, stall);
        end
        // Writeback to a register that is not pending leaves the scoreboard alone.
        do_write(5'd12, 64'hC0FFEE);
        rs1_addr = 5'd12;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs1_data !== 64'hC0FFEE || wb_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL clear_not_pending: busy=%b data=%h count=%0d expected 0/c0ffee/%0d",
                     rs1_busy, rs1_data, wb_count, exp_cnt);
        end
    endtask

    task automatic test_count_wrap();
        while (exp_cnt[3:0] != 4'hF) begin
            do_write(5'd2, 64'(exp_cnt));
        end
        n_cmp++;
        if (s_wb_count !== 4'hF || wb_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL count_preload: small=%0d full=%0d expected 15/%0d",
                     s_wb_count, wb_count, exp_cnt);
        end
        do_write(5'd2, 64'hFFFF);
        n_cmp++;
        if (s_wb_count !== 4'h0 || wb_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL count_wrap: small=%0d full=%0d expected 0/%0d",
                     s_wb_count, wb_count, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue_en = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd4;
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd4;
        @(posedge clk);
        #2;
        n_cmp++;
        if (rs1_data !== 64'hDEAD_BEEF || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async_reset: data=%h stall=%b expected deadbeef/1", rs1_data, stall);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rs1_data !== 64'h0 || stall !== 1'b0 || wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: data=%h stall=%b count=%0d expected 0/0/0",
                     rs1_data, stall, wb_count);
        end
        // A write presented while reset is held must be discarded.
        @(negedge clk);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h77;
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (rs1_data !== 64'h0 || wb_count !== 32'd0) begin
            n_fail++;
            $display("FAIL write_in_reset: data=%h count=%0d expected 0/0", rs1_data, wb_count);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        exp_cnt = 0;
        test_reset();
        test_bypass();
        test_x0_write();
        test_load_hazard();
        test_set_wins_and_flush();
        test_count_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
